snap_capture: RTL
=================

// Module: snap_capture
// PURPOSE
//  Free-running event/tick counter with request-driven snapshot hold for eCPU readback.
//  Output is transparent (live count) when idle; on cap_req the value is frozen until rd_ack.
//  Depth-2 capture queue (hold + pending); overrun is flagged sticky.
//  Feeds the downstream transparent mux/latch stage: snap_valid acts as its hold-select.
// PARAMETERS
//  W        32  counter / snapshot width (bits), 8..48
//  WRAP_W    8  wrap-count width; used only with SNAP_WRAP_CNT_EN
// PORTS
//  clk         in   1      system clock; sole clock domain
//  rst         in   1      asynchronous, active-high reset
//  cnt_en      in   1      counter increments on this clk edge when 1
//  cnt_clr     in   1      synchronous counter clear; priority over cnt_en
//  cap_req     in   1      single-cycle snapshot request
//  rd_ack      in   1      single-cycle: consumer has read q_out, release hold
//  ovr_clr     in   1      clears sticky overrun
//  q_out       out  W      live count when idle, held snapshot when snap_valid
//  snap_valid  out  1      1 = q_out is a frozen snapshot
//  pend_valid  out  1      1 = second snapshot queued behind q_out
//  overrun     out  1      sticky: cap_req dropped, queue full
//  wrap_cnt    out  WRAP_W held wrap count (SNAP_WRAP_CNT_EN only; else absent)
// BEHAVIOUR
//  Reset (async): cnt=0, state IDLE, hold=0, pend=0, pend_valid=0, overrun=0,
//   q_out=0, snap_valid=0, wrap_cnt=0.
//  Counter: cnt_clr -> 0; else cnt_en -> cnt+1 mod 2^W (2^W-1 wraps to 0, no flag).
//  Captured value = cnt as registered before edge N (pre-increment, pre-clear) when
//   cap_req is sampled at edge N; visible on q_out from cycle N+1 (1-cycle latency).
//  FSM states: IDLE, HELD.
//   IDLE: q_out=cnt (registered count, combinational mux). cap_req -> hold<=cnt, HELD.
//         rd_ack in IDLE ignored, including rd_ack with cap_req (capture still taken).
//   HELD: q_out=hold.
//    rd_ack only: pend_valid ? (hold<=pend, pend_valid<=0, stay HELD) : IDLE.
//    cap_req only: !pend_valid ? (pend<=cnt, pend_valid<=1) : (drop, overrun<=1).
//    rd_ack+cap_req: pend_valid ? (hold<=pend, pend<=cnt, pend_valid stays 1)
//                               : (hold<=cnt, stay HELD); never overrun.
//  overrun: set wins over ovr_clr in the same cycle.
//  Queue order strictly FIFO; oldest snapshot never overwritten.
//  rst mid-HELD discards hold and pend immediately; q_out reverts to 0.
// CONFIGURATION
//  SNAP_WRAP_CNT_EN defined: WRAP_W-bit wrap counter increments when cnt wraps
//   2^W-1->0 via cnt_en (not via cnt_clr; cnt_clr also clears it); captured
//   alongside cnt into hold/pend with identical queue rules; wrap_cnt mirrors q_out
//   mux (live when IDLE, held when HELD).
//  Undefined: no wrap counter, no wrap_cnt port, no extra storage.
// STRUCTURE
//  snap_pkg: state enum (ST_IDLE, ST_HELD), W/WRAP_W default localparams,
//   snapshot record typedef {cnt, wrap}.
//  Sub-module snap_counter: cnt + optional wrap counter, cnt_en/cnt_clr.
//  Top: FSM, hold/pend registers, overrun, output mux.
// TESTING
//  Reset: assert rst mid-count, cnt_en=1 -> q_out=0, all flags 0 asynchronously.
//  Basic: cnt at 41, cap_req -> q_out=41 next cycle, snap_valid=1 while cnt runs;
//   rd_ack -> snap_valid=0, q_out=live count.
//  Queue: cap_req at cnt=10 and cnt=20 -> q_out=10, pend_valid=1; rd_ack -> q_out=20,
//   pend_valid=0; rd_ack -> IDLE.
//  Overrun: three cap_req (5,6,7) without ack -> overrun=1, q_out=5, pend holds 6;
//   ovr_clr+4th cap_req same cycle -> overrun stays 1.
//  Simultaneous: HELD at 100, pend empty, rd_ack+cap_req at cnt=150 -> q_out=150, HELD;
//   cap_req+cnt_clr at cnt=2^W-1 -> captured 2^W-1, cnt=0.
//  SNAP_WRAP_CNT_EN, W=8: run 3 wraps, cap_req at cnt=7 -> q_out=7, wrap_cnt=3.

Source files
------------

// File: rtl/snap_pkg.sv
// Shared types for the snapshot-capture block: FSM states, default widths, snapshot record.
// The wrap field of snap_rec_t only carries data when SNAP_WRAP_CNT_EN is defined.
package snap_pkg;

  localparam int SNAP_W_DEF      = 32;
  localparam int SNAP_WRAP_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } snap_state_e;

  typedef struct packed {
    logic [SNAP_W_DEF-1:0]      cnt;
    logic [SNAP_WRAP_W_DEF-1:0] wrap;
  } snap_rec_t;

  // Sticky flag update where a same-cycle set beats a clear.
  function automatic logic sticky_next(input logic set, input logic clr, input logic cur);
    return set ? 1'b1 : (clr ? 1'b0 : cur);
  endfunction

endpackage

// File: rtl/snap_counter.sv
// Free-running count with synchronous clear (clear beats enable); next-edge update.
// With SNAP_WRAP_CNT_EN, also counts enable-driven wraps of the main counter.
module snap_counter
  import snap_pkg::*;
#(
  parameter int W = SNAP_W_DEF
`ifdef SNAP_WRAP_CNT_EN
  , parameter int WRAP_W = SNAP_WRAP_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic              cnt_clr,
`ifdef SNAP_WRAP_CNT_EN
  output logic [WRAP_W-1:0] wrap,
`endif
  output logic [W-1:0]      cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

`ifdef SNAP_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_d, wrap_q;

  // A clear zeroes both counters, so it never registers as a wrap.
  always_comb begin
    wrap_d = wrap_q;
    if (cnt_clr) begin
      wrap_d = '0;
    end else if (cnt_en && (&cnt_q)) begin
      wrap_d = wrap_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: rtl/snap_capture.sv
// Live counter with a depth-2 snapshot queue (hold + pending) for CPU readback; capture visible next cycle.
// No backpressure: cap_req with a full queue is dropped and flags sticky overrun. SNAP_WRAP_CNT_EN adds wrap_cnt.
module snap_capture
  import snap_pkg::*;
#(
  parameter int W = SNAP_W_DEF
`ifdef SNAP_WRAP_CNT_EN
  , parameter int WRAP_W = SNAP_WRAP_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic              cnt_clr,
  input  logic              cap_req,
  input  logic              rd_ack,
  input  logic              ovr_clr,
  output logic [W-1:0]      q_out,
  output logic              snap_valid,
  output logic              pend_valid,
`ifdef SNAP_WRAP_CNT_EN
  output logic [WRAP_W-1:0] wrap_cnt,
`endif
  output logic              overrun
);

`ifdef SNAP_WRAP_CNT_EN
  typedef struct packed {
    logic [W-1:0]      cnt;
    logic [WRAP_W-1:0] wrap;
  } rec_t;
`else
  typedef struct packed {
    logic [W-1:0] cnt;
  } rec_t;
`endif

  rec_t        live;
  rec_t        hold_d, hold_q;
  rec_t        pend_d, pend_q;
  rec_t        out_rec;
  logic        pend_valid_d, pend_valid_q;
  logic        overrun_d, overrun_q;
  logic        ovr_set;
  snap_state_e state_d, state_q;

  snap_counter #(
    .W      (W)
`ifdef SNAP_WRAP_CNT_EN
    , .WRAP_W (WRAP_W)
`endif
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
`ifdef SNAP_WRAP_CNT_EN
    .wrap    (live.wrap),
`endif
    .cnt     (live.cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving HELD needs an ack with nothing queued behind and no new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cap_req) state_d = ST_HELD;
      ST_HELD: if (rd_ack && !cap_req && !pend_valid_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_rec    = (state_q == ST_HELD) ? hold_q : live;
    snap_valid = (state_q == ST_HELD);
  end

  assign q_out      = out_rec.cnt;
  assign pend_valid = pend_valid_q;
  assign overrun    = overrun_q;
`ifdef SNAP_WRAP_CNT_EN
  assign wrap_cnt   = out_rec.wrap;
`endif

  // Captures always sample the pre-edge registered count, so a same-cycle clear does not affect them.
  always_comb begin
    hold_d       = hold_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ovr_set      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cap_req) hold_d = live;
      end
      ST_HELD: begin
        if (rd_ack && cap_req) begin
          if (pend_valid_q) begin
            hold_d = pend_q;
            pend_d = live;
          end else begin
            hold_d = live;
          end
        end else if (rd_ack) begin
          if (pend_valid_q) begin
            hold_d       = pend_q;
            pend_valid_d = 1'b0;
          end
        end else if (cap_req) begin
          if (pend_valid_q) begin
            ovr_set = 1'b1;
          end else begin
            pend_d       = live;
            pend_valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    overrun_d = sticky_next(ovr_set, ovr_clr, overrun_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule
